// File: rtl/volatility_ring_ctrl.sv
// volatility_ring_ctrl: per-stock ring-buffer addressing for the volatility sample RAM,
// issuing an eviction read one cycle ahead of each overwriting write.
module volatility_ring_ctrl #(
    parameter int NUM_STOCKS  = 4,
    parameter int BUFFER_SIZE = 20,
    parameter int SID_W       = $clog2(NUM_STOCKS),
    parameter int ADDR_W      = $clog2(NUM_STOCKS*BUFFER_SIZE),
    parameter int CNT_W       = $clog2(BUFFER_SIZE+1)
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_data_valid,
    input  logic [SID_W-1:0]      i_stock_id,
    output logic                  o_ready,
    input  logic                  i_flush,
    input  logic [SID_W-1:0]      i_flush_id,
    output logic                  o_rd_en,
    output logic [ADDR_W-1:0]     o_rd_addr,
    output logic                  o_wr_en,
    output logic [ADDR_W-1:0]     o_wr_addr,
    output logic [SID_W-1:0]      o_wr_stock_id,
    output logic                  o_evict,
    output logic [CNT_W-1:0]      o_count,
    output logic [NUM_STOCKS-1:0] o_full_mask
);
    logic [CNT_W-1:0]  ptr [NUM_STOCKS];
    logic [CNT_W-1:0]  cnt [NUM_STOCKS];
    logic              legal, accept, flush_ok, cur_full;
    logic [SID_W-1:0]  sid;
    logic [CNT_W-1:0]  cur_ptr, cur_cnt;
    logic [ADDR_W-1:0] cur_addr;
    logic              p_valid, p_evict;
    logic [ADDR_W-1:0] p_addr;
    logic [SID_W-1:0]  p_sid;
    logic [CNT_W-1:0]  p_count;

    assign o_ready  = !i_flush;
    assign legal    = int'(i_stock_id) < NUM_STOCKS;
    assign accept   = i_data_valid && !i_flush && legal;
    assign flush_ok = i_flush && (int'(i_flush_id) < NUM_STOCKS);
    assign sid      = legal ? i_stock_id : '0;
    assign cur_ptr  = ptr[sid];
    assign cur_cnt  = cnt[sid];
    assign cur_full = cur_cnt == CNT_W'(BUFFER_SIZE);
    assign cur_addr = ADDR_W'(int'(sid) * BUFFER_SIZE + int'(cur_ptr));

    // Stage 1 updates pointer state and issues the eviction read; stage 2 issues the write.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < NUM_STOCKS; i++) begin
                ptr[i] <= '0;
                cnt[i] <= '0;
            end
            o_full_mask   <= '0;
            o_rd_en       <= 1'b0;
            o_rd_addr     <= '0;
            p_valid       <= 1'b0;
            p_evict       <= 1'b0;
            p_addr        <= '0;
            p_sid         <= '0;
            p_count       <= '0;
            o_wr_en       <= 1'b0;
            o_wr_addr     <= '0;
            o_wr_stock_id <= '0;
            o_evict       <= 1'b0;
            o_count       <= '0;
        end else begin
            o_rd_en <= accept && cur_full;
            p_valid <= accept;
            if (accept) begin
                o_rd_addr        <= cur_addr;
                p_addr           <= cur_addr;
                p_sid            <= sid;
                p_evict          <= cur_full;
                p_count          <= cur_full ? cur_cnt : cur_cnt + 1'b1;
                ptr[sid]         <= (cur_ptr == CNT_W'(BUFFER_SIZE-1)) ? '0 : cur_ptr + 1'b1;
                cnt[sid]         <= cur_full ? cur_cnt : cur_cnt + 1'b1;
                o_full_mask[sid] <= cur_cnt >= CNT_W'(BUFFER_SIZE-1);
            end
            if (flush_ok) begin
                ptr[i_flush_id]         <= '0;
                cnt[i_flush_id]         <= '0;
                o_full_mask[i_flush_id] <= 1'b0;
            end
            o_wr_en <= p_valid;
            o_evict <= p_valid && p_evict;
            if (p_valid) begin
                o_wr_addr     <= p_addr;
                o_wr_stock_id <= p_sid;
                o_count       <= p_count;
            end
        end
    end
endmodule

// File: tb/tb_volatility_ring_ctrl.sv
// tb_volatility_ring_ctrl: directed + random checks of the ring controller against a
// fill-total reference model (address = base + total mod size, count = min(total, size)).
module tb_volatility_ring_ctrl;
    localparam int NS = 4;
    localparam int BS = 20;

    logic       clk = 0;
    logic       rst_n = 0;
    logic       data_valid = 0, flush = 0;
    logic [1:0] stock_id = 0, flush_id = 0;
    logic       ready, rd_en, wr_en, evict;
    logic [6:0] rd_addr, wr_addr;
    logic [1:0] wr_sid;
    logic [4:0] count;
    logic [3:0] full_mask;

    logic       v3 = 0;
    logic [1:0] id3 = 0;
    logic       ready3, rd_en3, wr_en3, evict3;
    logic [5:0] rd_addr3, wr_addr3;
    logic [1:0] wr_sid3;
    logic [4:0] count3;
    logic [2:0] full_mask3;

    int n_cmp = 0, n_bad = 0;
    int total [NS];

    typedef struct {logic v; int addr; int sid; logic ev; int cnt;} exp_t;
    exp_t s1, s2;

    always #5 clk = ~clk;

    volatility_ring_ctrl #(.NUM_STOCKS(NS), .BUFFER_SIZE(BS)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_data_valid(data_valid), .i_stock_id(stock_id),
        .o_ready(ready), .i_flush(flush), .i_flush_id(flush_id), .o_rd_en(rd_en),
        .o_rd_addr(rd_addr), .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_stock_id(wr_sid),
        .o_evict(evict), .o_count(count), .o_full_mask(full_mask));

    volatility_ring_ctrl #(.NUM_STOCKS(3), .BUFFER_SIZE(BS)) dut3 (
        .i_clk(clk), .i_reset_n(rst_n), .i_data_valid(v3), .i_stock_id(id3),
        .o_ready(ready3), .i_flush(1'b0), .i_flush_id(2'd0), .o_rd_en(rd_en3),
        .o_rd_addr(rd_addr3), .o_wr_en(wr_en3), .o_wr_addr(wr_addr3), .o_wr_stock_id(wr_sid3),
        .o_evict(evict3), .o_count(count3), .o_full_mask(full_mask3));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NS; i++) total[i] = 0;
        s1 = '{1'b0, 0, 0, 1'b0, 0};
        s2 = s1;
    endtask

    function automatic logic [3:0] mask_exp();
        logic [3:0] m;
        for (int i = 0; i < NS; i++) m[i] = total[i] >= BS;
        return m;
    endfunction

    // One clock: drive inputs, advance the model at the edge, check all outputs after it.
    task automatic step(input logic v, input int sid, input logic f, input int fid);
        data_valid = v; stock_id = 2'(sid); flush = f; flush_id = 2'(fid);
        #1 chk("ready", 32'(ready), 32'(!f));
        @(posedge clk);
        s2 = s1;
        s1.v = v && !f;
        if (s1.v) begin
            s1.addr = sid * BS + total[sid] % BS;
            s1.sid  = sid;
            s1.ev   = total[sid] >= BS;
            s1.cnt  = (total[sid] + 1 < BS) ? total[sid] + 1 : BS;
            total[sid]++;
        end
        if (f) total[fid] = 0;
        #1;
        chk("rd_en", 32'(rd_en), 32'(s1.v && s1.ev));
        if (s1.v && s1.ev) chk("rd_addr", 32'(rd_addr), 32'(s1.addr));
        chk("wr_en", 32'(wr_en), 32'(s2.v));
        if (s2.v) begin
            chk("wr_addr", 32'(wr_addr), 32'(s2.addr));
            chk("wr_sid", 32'(wr_sid), 32'(s2.sid));
            chk("evict", 32'(evict), 32'(s2.ev));
            chk("count", 32'(count), 32'(s2.cnt));
        end else chk("evict_idle", 32'(evict), 32'd0);
        chk("full_mask", 32'(full_mask), 32'(mask_exp()));
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_en", 32'(rd_en), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_evict", 32'(evict), 32'd0);
        chk("rst_mask", 32'(full_mask), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        @(negedge clk) rst_n = 1;
        chk("rst_ready", 32'(ready), 32'd1);

        // Fill stock 2, then two overwrites
        for (int i = 0; i < 22; i++) step(1, 2, 0, 0);
        repeat (2) step(0, 0, 0, 0);
        chk("t1_mask", 32'(full_mask), 32'h4);

        // Interleave two empty stocks without gaps
        for (int i = 0; i < 4; i++) step(1, (i % 2) ? 3 : 0, 0, 0);
        repeat (2) step(0, 0, 0, 0);

        // Fill stock 1, flush it with valid high, then refill
        for (int i = 0; i < BS; i++) step(1, 1, 0, 0);
        step(1, 1, 1, 1);
        step(1, 1, 0, 0);
        repeat (2) step(0, 0, 0, 0);
        chk("t4_mask1", 32'(full_mask[1]), 32'd0);

        // Asynchronous reset mid-burst on a full stock
        repeat (3) step(1, 2, 0, 0);
        data_valid = 0;
        #2 rst_n = 0;
        #1;
        chk("async_rd_en", 32'(rd_en), 32'd0);
        chk("async_wr_en", 32'(wr_en), 32'd0);
        chk("async_mask", 32'(full_mask), 32'd0);
        model_reset();
        @(negedge clk) rst_n = 1;
        step(1, 0, 0, 0);
        repeat (2) step(0, 0, 0, 0);

        // Illegal stock id on a 3-stock build is dropped
        v3 = 1; id3 = 2'd3;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("ill_wr_en", 32'(wr_en3), 32'd0);
            chk("ill_rd_en", 32'(rd_en3), 32'd0);
            chk("ill_mask", 32'(full_mask3), 32'd0);
        end
        id3 = 2'd2;
        @(posedge clk);
        #1 v3 = 0;
        @(posedge clk);
        #1;
        chk("ill_after_wr_en", 32'(wr_en3), 32'd1);
        chk("ill_after_addr", 32'(wr_addr3), 32'd40);
        chk("ill_after_count", 32'(count3), 32'd1);
        chk("ill_after_evict", 32'(evict3), 32'd0);

        // Random mix of stocks, idles and flushes
        for (int i = 0; i < 600; i++) begin
            logic f;
            f = $urandom_range(0, 15) == 0;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3), f, $urandom_range(0, 3));
        end
        repeat (2) step(0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
